// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the two-requester memory bus sequencer.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  localparam int unsigned TIMEOUT_CYCLES_DEF = 16;

endpackage

// File: rtl/bus_timeout_ctr.sv
// Counts ACCESS cycles that end without Ready; present only when BUS_TIMEOUT_EN is defined.
`ifdef BUS_TIMEOUT_EN
module bus_timeout_ctr #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = (LIMIT < 2) ? 1 : $clog2(LIMIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The current cycle is the last one allowed without Ready.
  assign expired = (cnt_q == CNT_W'(LIMIT - 1));

endmodule
`endif

// File: rtl/mem_bus_sequencer.sv
// Arbitrates the external memory bus between instruction fetch and data ports.
// Optional access timeout enabled by defining BUS_TIMEOUT_EN.
module mem_bus_sequencer
  import mem_bus_pkg::*;
#(
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              i_IF_Req,
  input  logic [ADDR_W-1:0] i_IF_Addr,
  output logic              o_IF_Ack,
  output logic [DATA_W-1:0] o_IF_RData,
  input  logic              i_D_Req,
  input  logic              i_D_RW,
  input  logic [ADDR_W-1:0] i_D_Addr,
  input  logic [DATA_W-1:0] i_D_WData,
  output logic              o_D_Ack,
  output logic [DATA_W-1:0] o_D_RData,
  output logic              o_Err,
  output logic [ADDR_W-1:0] o_Addres_Bus,
  output logic [DATA_W-1:0] o_DataOut_Bus,
  output logic              o_RW,
  output logic              o_Strobe,
  input  logic [DATA_W-1:0] i_DataIn_Bus,
  input  logic              i_Ready
);

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be nonzero");
  end

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  owner_e            last_grant_q, last_grant_d;
  logic              if_ack_q, if_ack_d;
  logic              d_ack_q, d_ack_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rw_q, rw_d;
  logic              strobe_q, strobe_d;
  logic              timeout_hit;

`ifdef BUS_TIMEOUT_EN
  bus_timeout_ctr #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk     (Clk),
    .rst_n   (Rst),
    .clear   (state_q != ACCESS),
    .enable  ((state_q == ACCESS) && !i_Ready),
    .expired (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  // Next state and next registered outputs; bus is zero unless in ACCESS.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    if_ack_d     = 1'b0;
    d_ack_d      = 1'b0;
    err_d        = 1'b0;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    addr_d       = '0;
    wdata_d      = '0;
    rw_d         = RW_READ;
    strobe_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (i_IF_Req || i_D_Req) begin
          if (i_IF_Req && i_D_Req) begin
            owner_d = (last_grant_q == OWN_IF) ? OWN_D : OWN_IF;
          end else begin
            owner_d = i_D_Req ? OWN_D : OWN_IF;
          end
          state_d  = ACCESS;
          strobe_d = 1'b1;
          if (owner_d == OWN_D) begin
            addr_d  = i_D_Addr;
            rw_d    = i_D_RW;
            wdata_d = (i_D_RW == RW_WRITE) ? i_D_WData : '0;
          end else begin
            addr_d  = i_IF_Addr;
          end
        end
      end
      ACCESS: begin
        if (i_Ready || timeout_hit) begin
          state_d      = RESP;
          last_grant_d = owner_q;
          err_d        = !i_Ready;
          if (owner_q == OWN_IF) begin
            if_ack_d   = 1'b1;
            if_rdata_d = i_Ready ? i_DataIn_Bus : '1;
          end else begin
            d_ack_d = 1'b1;
            if (!i_Ready) begin
              d_rdata_d = '1;
            end else if (rw_q == RW_READ) begin
              d_rdata_d = i_DataIn_Bus;
            end
          end
        end else begin
          strobe_d = 1'b1;
          addr_d   = addr_q;
          wdata_d  = wdata_q;
          rw_d     = rw_q;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q      <= IDLE;
      owner_q      <= OWN_IF;
      last_grant_q <= OWN_IF;
      if_ack_q     <= 1'b0;
      d_ack_q      <= 1'b0;
      err_q        <= 1'b0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rw_q         <= RW_READ;
      strobe_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      if_ack_q     <= if_ack_d;
      d_ack_q      <= d_ack_d;
      err_q        <= err_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rw_q         <= rw_d;
      strobe_q     <= strobe_d;
    end
  end

  assign o_IF_Ack      = if_ack_q;
  assign o_IF_RData    = if_rdata_q;
  assign o_D_Ack       = d_ack_q;
  assign o_D_RData     = d_rdata_q;
  assign o_Err         = err_q;
  assign o_Addres_Bus  = addr_q;
  assign o_DataOut_Bus = wdata_q;
  assign o_RW          = rw_q;
  assign o_Strobe      = strobe_q;

endmodule

// File: tb/tb_mem_bus_sequencer.sv
// Self-checking bench for mem_bus_sequencer: transaction-level model plus directed scenarios.
// Timeout expectations follow BUS_TIMEOUT_EN.
module tb_mem_bus_sequencer;

`ifdef BUS_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int TO_CYC = 16;

  logic       Clk = 1'b0;
  logic       Rst = 1'b0;
  logic       i_IF_Req = 1'b0;
  logic [7:0] i_IF_Addr = 8'h00;
  logic       o_IF_Ack;
  logic [7:0] o_IF_RData;
  logic       i_D_Req = 1'b0;
  logic       i_D_RW = 1'b0;
  logic [7:0] i_D_Addr = 8'h00;
  logic [7:0] i_D_WData = 8'h00;
  logic       o_D_Ack;
  logic [7:0] o_D_RData;
  logic       o_Err;
  logic [7:0] o_Addres_Bus;
  logic [7:0] o_DataOut_Bus;
  logic       o_RW;
  logic       o_Strobe;
  logic [7:0] i_DataIn_Bus;
  logic       i_Ready = 1'b0;

  logic [7:0] mem [256];
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  mem_bus_sequencer dut (
    .Clk(Clk), .Rst(Rst),
    .i_IF_Req(i_IF_Req), .i_IF_Addr(i_IF_Addr), .o_IF_Ack(o_IF_Ack), .o_IF_RData(o_IF_RData),
    .i_D_Req(i_D_Req), .i_D_RW(i_D_RW), .i_D_Addr(i_D_Addr), .i_D_WData(i_D_WData),
    .o_D_Ack(o_D_Ack), .o_D_RData(o_D_RData), .o_Err(o_Err),
    .o_Addres_Bus(o_Addres_Bus), .o_DataOut_Bus(o_DataOut_Bus), .o_RW(o_RW), .o_Strobe(o_Strobe),
    .i_DataIn_Bus(i_DataIn_Bus), .i_Ready(i_Ready)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  // Memory responder: read data follows whatever address the bus presents.
  assign i_DataIn_Bus = mem[o_Addres_Bus];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction model: one bus owner at a time, ack one cycle after completion, then a gap.
  bit       m_busy = 1'b0, m_resp = 1'b0, m_err = 1'b0;
  bit       m_own_d = 1'b0, m_last_d = 1'b0, m_rw = 1'b0;
  bit [7:0] m_addr = 8'h00, m_wdata = 8'h00, m_if_rd = 8'h00, m_d_rd = 8'h00;
  int       m_wait = 0;

  always @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      m_busy = 0; m_resp = 0; m_err = 0; m_own_d = 0; m_last_d = 0; m_rw = 0;
      m_addr = 0; m_wdata = 0; m_if_rd = 0; m_d_rd = 0; m_wait = 0;
    end else if (m_resp) begin
      m_resp = 0;
      m_err  = 0;
    end else if (m_busy) begin
      if (!i_Ready) m_wait++;
      if (i_Ready || (TO_EN && m_wait == TO_CYC)) begin
        m_busy   = 0;
        m_resp   = 1;
        m_err    = !i_Ready;
        m_last_d = m_own_d;
        if (!m_own_d) m_if_rd = i_Ready ? mem[m_addr] : 8'hFF;
        else if (!i_Ready) m_d_rd = 8'hFF;
        else if (!m_rw) m_d_rd = mem[m_addr];
      end
    end else if (i_IF_Req || i_D_Req) begin
      m_own_d = (i_IF_Req && i_D_Req) ? !m_last_d : i_D_Req;
      m_busy  = 1;
      m_wait  = 0;
      m_addr  = m_own_d ? i_D_Addr : i_IF_Addr;
      m_rw    = m_own_d ? i_D_RW : 1'b0;
      m_wdata = i_D_WData;
    end
  end

  always @(negedge Clk) begin
    chk("strobe",   32'(o_Strobe),      32'(m_busy));
    chk("addr",     32'(o_Addres_Bus),  32'(m_busy ? m_addr : 8'h00));
    chk("dataout",  32'(o_DataOut_Bus), 32'((m_busy && m_own_d && m_rw) ? m_wdata : 8'h00));
    chk("rw",       32'(o_RW),          32'(m_busy && m_own_d && m_rw));
    chk("if_ack",   32'(o_IF_Ack),      32'(m_resp && !m_own_d));
    chk("d_ack",    32'(o_D_Ack),       32'(m_resp && m_own_d));
    chk("err",      32'(o_Err),         32'(m_resp && m_err));
    chk("if_rdata", 32'(o_IF_RData),    32'(m_if_rd));
    chk("d_rdata",  32'(o_D_RData),     32'(m_d_rd));
  end

  task automatic wait_ack(input bit want_d, input int budget);
    bit seen = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      @(negedge Clk);
      if (want_d ? o_D_Ack : o_IF_Ack) seen = 1'b1;
    end
    chk(want_d ? "d_ack_wait" : "if_ack_wait", 32'(seen), 32'd1);
    if (want_d) i_D_Req = 1'b0;
    else        i_IF_Req = 1'b0;
  endtask

  task automatic zero_outputs(input string tag);
    chk({tag, "_strobe"},   32'(o_Strobe),      32'd0);
    chk({tag, "_addr"},     32'(o_Addres_Bus),  32'd0);
    chk({tag, "_dataout"},  32'(o_DataOut_Bus), 32'd0);
    chk({tag, "_rw"},       32'(o_RW),          32'd0);
    chk({tag, "_acks"},     32'({o_IF_Ack, o_D_Ack, o_Err}), 32'd0);
    chk({tag, "_if_rdata"}, 32'(o_IF_RData),    32'd0);
    chk({tag, "_d_rdata"},  32'(o_D_RData),     32'd0);
  endtask

  bit who [4];
  int at  [4];
  int nack, scnt, acnt, ecnt;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i ^ 8'h5A);
    mem[8'h10] = 8'h3C; mem[8'h05] = 8'h77; mem[8'h80] = 8'h99; mem[8'h33] = 8'hC7;

    // Reset state
    repeat (2) @(negedge Clk);
    zero_outputs("reset");
    #2 Rst = 1'b1;
    @(negedge Clk);

    // 1: IF read with zero wait states
    i_IF_Addr = 8'h10; i_Ready = 1'b1; i_IF_Req = 1'b1;
    @(negedge Clk);
    chk("s1_strobe", 32'(o_Strobe), 32'd1);
    chk("s1_addr", 32'(o_Addres_Bus), 32'h10);
    chk("s1_rw", 32'(o_RW), 32'd0);
    @(negedge Clk);
    chk("s1_ack", 32'(o_IF_Ack), 32'd1);
    chk("s1_rdata", 32'(o_IF_RData), 32'h3C);
    i_IF_Req = 1'b0;
    repeat (2) @(negedge Clk);

    // 6: D read result held across a following IF access
    i_D_Addr = 8'h05; i_D_RW = 1'b0; i_D_Req = 1'b1;
    wait_ack(1'b1, 10);
    chk("s6_d_rdata", 32'(o_D_RData), 32'h77);
    @(negedge Clk);
    i_IF_Addr = 8'h10; i_Ready = 1'b0; i_IF_Req = 1'b1;
    repeat (3) begin
      @(negedge Clk);
      chk("s6_hold", 32'(o_D_RData), 32'h77);
    end
    i_Ready = 1'b1;
    wait_ack(1'b0, 10);
    chk("s6_hold_at_if_ack", 32'(o_D_RData), 32'h77);
    chk("s6_if_rdata", 32'(o_IF_RData), 32'h3C);
    repeat (2) @(negedge Clk);

    // 2: D write with two wait states
    i_D_Addr = 8'h80; i_D_RW = 1'b1; i_D_WData = 8'hA5; i_Ready = 1'b0; i_D_Req = 1'b1;
    scnt = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge Clk);
      if (o_Strobe) begin
        scnt++;
        chk("s2_dataout", 32'(o_DataOut_Bus), 32'hA5);
        chk("s2_rw", 32'(o_RW), 32'd1);
      end
      if (k == 3) i_Ready = 1'b1;
      if (k == 4) begin
        chk("s2_ack_cycle4", 32'(o_D_Ack), 32'd1);
        chk("s2_rdata_kept", 32'(o_D_RData), 32'h77);
        i_D_Req = 1'b0;
      end
    end
    chk("s2_strobe_cycles", 32'(scnt), 32'd3);
    i_D_RW = 1'b0;
    repeat (2) @(negedge Clk);

    // 4: reset during a D read access
    i_D_Addr = 8'h05; i_Ready = 1'b0; i_D_Req = 1'b1;
    @(negedge Clk);
    chk("s4_in_access", 32'(o_Strobe), 32'd1);
    i_D_Req = 1'b0; i_IF_Addr = 8'h33; i_IF_Req = 1'b1;
    #2 Rst = 1'b0;
    #1 zero_outputs("s4_async");
    @(negedge Clk);
    #2 Rst = 1'b1; i_Ready = 1'b1;
    wait_ack(1'b0, 10);
    chk("s4_if_rdata", 32'(o_IF_RData), 32'hC7);
    chk("s4_d_rdata_cleared", 32'(o_D_RData), 32'd0);
    repeat (2) @(negedge Clk);

    // 3: both requesters held after reset alternate D, IF, D, IF
    @(negedge Clk); #2 Rst = 1'b0;
    @(negedge Clk); #2 Rst = 1'b1;
    @(negedge Clk);
    i_IF_Addr = 8'h20; i_D_Addr = 8'h40; i_D_RW = 1'b0; i_Ready = 1'b1;
    i_IF_Req = 1'b1; i_D_Req = 1'b1;
    nack = 0;
    for (int k = 0; k < 20 && nack < 4; k++) begin
      @(negedge Clk);
      if (o_D_Ack || o_IF_Ack) begin
        who[nack] = o_D_Ack;
        at[nack]  = cyc;
        nack++;
      end
    end
    i_IF_Req = 1'b0; i_D_Req = 1'b0;
    chk("s3_ack_count", 32'(nack), 32'd4);
    chk("s3_order", 32'({who[0], who[1], who[2], who[3]}), 32'b1010);
    chk("s3_gap1", 32'(at[1] - at[0]), 32'd3);
    chk("s3_gap2", 32'(at[2] - at[1]), 32'd3);
    chk("s3_gap3", 32'(at[3] - at[2]), 32'd3);
    chk("s3_if_rdata", 32'(o_IF_RData), 32'h7A);
    chk("s3_d_rdata", 32'(o_D_RData), 32'h1A);
    repeat (2) @(negedge Clk);

    // 5: D read with Ready withheld
    i_D_Addr = 8'h60; i_D_RW = 1'b0; i_Ready = 1'b0; i_D_Req = 1'b1;
    scnt = 0; acnt = 0; ecnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge Clk);
      if (o_Strobe) scnt++;
      if (o_Err) ecnt++;
      if (o_D_Ack) begin
        acnt++;
        chk("s5_d_rdata_ff", 32'(o_D_RData), 32'hFF);
        i_D_Req = 1'b0;
      end
    end
`ifdef BUS_TIMEOUT_EN
    chk("s5_strobe_cycles", 32'(scnt), 32'd16);
    chk("s5_acks", 32'(acnt), 32'd1);
    chk("s5_err_pulses", 32'(ecnt), 32'd1);
`else
    chk("s5_strobe_cycles", 32'(scnt), 32'd20);
    chk("s5_acks", 32'(acnt), 32'd0);
    chk("s5_err_pulses", 32'(ecnt), 32'd0);
    i_Ready = 1'b1;
    wait_ack(1'b1, 5);
    chk("s5_late_rdata", 32'(o_D_RData), 32'h3A);
`endif
    repeat (2) @(negedge Clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
